// File: rtl/stack_cpu_controller.sv
// stack_cpu_controller: multicycle control FSM for the stack-machine CPU.
// Issues fetch/decode sequencing, stack pulses, and halts on stack over/underflow.
`default_nettype none

module stack_cpu_controller #(
    parameter int STACK_DEPTH = 32,
    parameter int DEPTH_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         opcode,
    input  logic               zero,
    output logic               pc_write,
    output logic               pc_src,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               push,
    output logic               pop,
    output logic               tos,
    output logic               push_src,
    output logic               a_write,
    output logic               b_write,
    output logic [1:0]         alu_op,
    output logic               halted,
    output logic [DEPTH_W-1:0] depth
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_POP_A   = 4'd2,
        S_LD_A    = 4'd3,
        S_POP_B   = 4'd4,
        S_LD_B    = 4'd5,
        S_EXEC    = 4'd6,
        S_PUSH_RD = 4'd7,
        S_PUSH_WR = 4'd8,
        S_POP_ST  = 4'd9,
        S_POP_WR  = 4'd10,
        S_JMP     = 4'd11,
        S_TOS     = 4'd12,
        S_JZ_CHK  = 4'd13,
        S_HALT    = 4'd14
    } state_t;

    state_t state;
    logic   fault;

    // Stack-safety check, evaluated in ID before any stack pulse is issued.
    always_comb begin
        fault = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND: fault = (depth < DEPTH_TWO);
            OP_NOT, OP_POP, OP_JZ:  fault = (depth == '0);
            OP_PUSH:                fault = (depth == DEPTH_FULL);
            default:                fault = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IF;
            depth  <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    if (fault) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_PUSH: state <= S_PUSH_RD;
                            OP_POP:  state <= S_POP_ST;
                            OP_JMP:  state <= S_JMP;
                            OP_JZ:   state <= S_TOS;
                            default: state <= S_POP_A;
                        endcase
                    end
                end
                S_POP_A: begin
                    depth <= depth - DEPTH_ONE;
                    state <= S_LD_A;
                end
                S_LD_A:  state <= (opcode == OP_NOT) ? S_EXEC : S_POP_B;
                S_POP_B: begin
                    depth <= depth - DEPTH_ONE;
                    state <= S_LD_B;
                end
                S_LD_B:  state <= S_EXEC;
                S_EXEC: begin
                    depth <= depth + DEPTH_ONE;
                    state <= S_IF;
                end
                S_PUSH_RD: state <= S_PUSH_WR;
                S_PUSH_WR: begin
                    depth <= depth + DEPTH_ONE;
                    state <= S_IF;
                end
                S_POP_ST: begin
                    depth <= depth - DEPTH_ONE;
                    state <= S_POP_WR;
                end
                S_POP_WR: state <= S_IF;
                S_JMP:    state <= S_IF;
                S_TOS:    state <= S_JZ_CHK;
                S_JZ_CHK: state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_HALT;
            endcase
        end
    end

    // Moore decode; masked by rst so an abort silences every strobe at once.
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        mdr_write = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        tos       = 1'b0;
        push_src  = 1'b0;
        a_write   = 1'b0;
        b_write   = 1'b0;
        alu_op    = 2'b00;
        if (!rst) begin
            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_POP_A, S_POP_B, S_POP_ST: pop = 1'b1;
                S_LD_A: a_write = 1'b1;
                S_LD_B: b_write = 1'b1;
                S_EXEC: begin
                    push     = 1'b1;
                    push_src = 1'b1;
                    alu_op   = opcode[1:0];
                end
                S_PUSH_RD: begin
                    mem_read  = 1'b1;
                    iord      = 1'b1;
                    mdr_write = 1'b1;
                end
                S_PUSH_WR: push = 1'b1;
                S_POP_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_JMP: begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
                S_TOS: tos = 1'b1;
                S_JZ_CHK: begin
                    pc_write = zero;
                    pc_src   = zero;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_cpu_controller.sv
// tb_stack_cpu_controller: directed cycle-by-cycle check of the control words,
// tracked depth and halt flag against hand-derived expectations.
`default_nettype none

module tb_stack_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic       zero = 1'b0;
    logic       pc_write, pc_src, iord, mem_read, mem_write, ir_write, mdr_write;
    logic       push, pop, tos, push_src, a_write, b_write, halted;
    logic [1:0] alu_op;
    logic [5:0] depth;

    int n_tests = 0;
    int n_fail  = 0;

    // Control word order:
    // pc_write,pc_src,iord,mem_read,mem_write,ir_write,mdr_write,push,pop,tos,push_src,a_write,b_write,alu_op[1:0]
    localparam logic [14:0] W_ZERO = 15'b0;
    localparam logic [14:0] W_IF   = 15'b1_0_0_1_0_1_0_0_0_0_0_0_0_00;
    localparam logic [14:0] W_POP  = 15'b0_0_0_0_0_0_0_0_1_0_0_0_0_00;
    localparam logic [14:0] W_LDA  = 15'b0_0_0_0_0_0_0_0_0_0_0_1_0_00;
    localparam logic [14:0] W_LDB  = 15'b0_0_0_0_0_0_0_0_0_0_0_0_1_00;
    localparam logic [14:0] W_EXEC = 15'b0_0_0_0_0_0_0_1_0_0_1_0_0_00;
    localparam logic [14:0] W_PRD  = 15'b0_0_1_1_0_0_1_0_0_0_0_0_0_00;
    localparam logic [14:0] W_PWR  = 15'b0_0_0_0_0_0_0_1_0_0_0_0_0_00;
    localparam logic [14:0] W_MWR  = 15'b0_0_1_0_1_0_0_0_0_0_0_0_0_00;
    localparam logic [14:0] W_JMP  = 15'b1_1_0_0_0_0_0_0_0_0_0_0_0_00;
    localparam logic [14:0] W_TOS  = 15'b0_0_0_0_0_0_0_0_0_1_0_0_0_00;

    wire [14:0] ctl = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, mdr_write,
                       push, pop, tos, push_src, a_write, b_write, alu_op};

    stack_cpu_controller #(.STACK_DEPTH(32), .DEPTH_W(6)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .push(push), .pop(pop), .tos(tos), .push_src(push_src),
        .a_write(a_write), .b_write(b_write), .alu_op(alu_op),
        .halted(halted), .depth(depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle, then advance to the middle of the next one.
    task automatic step(input string tag, input logic [14:0] w, input int d, input bit h);
        #1;
        check({tag, ".ctl"}, 32'(ctl), 32'(w));
        check({tag, ".depth"}, 32'(depth), d);
        check({tag, ".halted"}, 32'(halted), 32'(h));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_push(input string tag, input int d);
        opcode = 3'b100;
        step({tag, ".if"}, W_IF, d, 1'b0);
        step({tag, ".id"}, W_ZERO, d, 1'b0);
        step({tag, ".rd"}, W_PRD, d, 1'b0);
        step({tag, ".wr"}, W_PWR, d, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".rst_ctl"}, 32'(ctl), 0);
        check({tag, ".rst_depth"}, 32'(depth), 0);
        check({tag, ".rst_halted"}, 32'(halted), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        do_reset("init");

        // PUSH 5, PUSH 3, ADD, POP to memory
        do_push("push5", 0);
        do_push("push3", 1);
        opcode = 3'b000;
        step("add.if",   W_IF,   2, 1'b0);
        step("add.id",   W_ZERO, 2, 1'b0);
        step("add.popa", W_POP,  2, 1'b0);
        step("add.lda",  W_LDA,  1, 1'b0);
        step("add.popb", W_POP,  1, 1'b0);
        step("add.ldb",  W_LDB,  0, 1'b0);
        step("add.exec", W_EXEC | 15'd0, 0, 1'b0);
        opcode = 3'b101;
        step("pop.if",   W_IF,   1, 1'b0);
        step("pop.id",   W_ZERO, 1, 1'b0);
        step("pop.st",   W_POP,  1, 1'b0);
        step("pop.wr",   W_MWR,  0, 1'b0);

        // NOT with depth 1
        do_push("push_n", 0);
        opcode = 3'b011;
        step("not.if",   W_IF,   1, 1'b0);
        step("not.id",   W_ZERO, 1, 1'b0);
        step("not.popa", W_POP,  1, 1'b0);
        step("not.lda",  W_LDA,  0, 1'b0);
        step("not.exec", W_EXEC | 15'd3, 0, 1'b0);

        // JZ taken and not taken, then JMP
        opcode = 3'b111;
        zero = 1'b1;
        step("jz1.if",  W_IF,   1, 1'b0);
        step("jz1.id",  W_ZERO, 1, 1'b0);
        step("jz1.tos", W_TOS,  1, 1'b0);
        step("jz1.chk", W_JMP,  1, 1'b0);
        zero = 1'b0;
        step("jz0.if",  W_IF,   1, 1'b0);
        step("jz0.id",  W_ZERO, 1, 1'b0);
        step("jz0.tos", W_TOS,  1, 1'b0);
        step("jz0.chk", W_ZERO, 1, 1'b0);
        opcode = 3'b110;
        step("jmp.if",  W_IF,   1, 1'b0);
        step("jmp.id",  W_ZERO, 1, 1'b0);
        step("jmp.go",  W_JMP,  1, 1'b0);

        // Underflow: ADD with one entry halts with no pop
        opcode = 3'b000;
        step("uf.if", W_IF,   1, 1'b0);
        step("uf.id", W_ZERO, 1, 1'b0);
        for (int i = 0; i < 20; i++) step("uf.halt", W_ZERO, 1, 1'b1);
        do_reset("uf");
        step("uf.after", W_IF, 0, 1'b0);
        step("uf.after_id", W_ZERO, 0, 1'b0);

        // Overflow: 32 pushes fill the stack, the 33rd halts
        do_reset("of");
        for (int i = 0; i < 32; i++) do_push("of.push", i);
        opcode = 3'b100;
        step("of.if", W_IF,   32, 1'b0);
        step("of.id", W_ZERO, 32, 1'b0);
        for (int i = 0; i < 4; i++) step("of.halt", W_ZERO, 32, 1'b1);

        // Reset during LD_A of SUB aborts immediately
        do_reset("ab");
        do_push("ab.p0", 0);
        do_push("ab.p1", 1);
        opcode = 3'b001;
        step("sub.if",   W_IF,   2, 1'b0);
        step("sub.id",   W_ZERO, 2, 1'b0);
        step("sub.popa", W_POP,  2, 1'b0);
        #1;
        check("sub.lda", 32'(ctl), 32'(W_LDA));
        rst = 1'b1;
        #1;
        check("abort.ctl", 32'(ctl), 0);
        check("abort.depth", 32'(depth), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("abort.if", W_IF,   0, 1'b0);
        step("abort.id", W_ZERO, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
